// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl: HD44780 write-only controller with power-up init sequence and byte command port
module lcd_hd44780_ctrl #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BUS_WIDTH  = 4,
  parameter int unsigned TWO_LINE   = 1,
  parameter int unsigned POWERUP_US = 20000,
  parameter int unsigned EXEC_US    = 50,
  parameter int unsigned CLEAR_US   = 2000
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 cmd_valid,
  input  logic                 cmd_rs,
  input  logic [7:0]           cmd_data,
  output logic                 cmd_ready,
  output logic                 init_done,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e,
  output logic [BUS_WIDTH-1:0] lcd_data
);
  localparam int unsigned TICK = CLK_HZ / 1_000_000;
  localparam logic [31:0] TICK_C = 32'(TICK);
  localparam logic [31:0] PWR_C = 32'(POWERUP_US * TICK);
  localparam logic [3:0] FB = BUS_WIDTH == 8 ? 4'd3 : 4'd4;
  localparam logic [3:0] LAST = FB + 4'd4;
  localparam logic [7:0] FSET = 8'h20 | (BUS_WIDTH == 8 ? 8'h10 : 8'h00) | (TWO_LINE != 0 ? 8'h08 : 8'h00);
  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SETUP, E_HIGH, HOLD, EXEC_WAIT} state_t;
  state_t state;
  logic [31:0] cnt, wait_clks, lim, src_us, rom_us;
  logic [3:0] step, rom_idx, lo_r;
  logic [7:0] rom_byte, src_byte;
  logic two, second, done, start, src_two, src_rs;
  function automatic logic [31:0] wait_us(input logic rs, input logic [5:0] hi);
    return (!rs && hi == 6'd0) ? 32'(CLEAR_US) : 32'(EXEC_US);
  endfunction
  assign lcd_rw = 1'b0;
  always_comb begin
    rom_idx = state == PWR_WAIT ? 4'd0 : step + 4'd1;
    rom_byte = rom_idx < FB ? ((BUS_WIDTH == 4 && rom_idx == 4'd3) ? 8'h20 : 8'h30) :
               rom_idx == FB ? FSET :
               rom_idx == FB + 4'd1 ? 8'h08 :
               rom_idx == FB + 4'd2 ? 8'h01 :
               rom_idx == FB + 4'd3 ? 8'h06 : 8'h0c;
    rom_us = rom_idx == 4'd0 ? 32'd4100 : rom_idx < FB ? 32'd100 : wait_us(1'b0, rom_byte[7:2]);
    src_byte = state == IDLE ? cmd_data : rom_byte;
    src_rs = state == IDLE && cmd_rs;
    src_two = BUS_WIDTH == 4 && (state == IDLE || rom_idx >= FB);
    src_us = state == IDLE ? wait_us(cmd_rs, cmd_data[7:2]) : rom_us;
    lim = state == PWR_WAIT ? PWR_C : (state == INIT || state == EXEC_WAIT) ? wait_clks : TICK_C;
    done = cnt == lim - 32'd1;
    start = (cmd_valid && cmd_ready) || (done && (state == PWR_WAIT || (state == INIT && step != LAST)));
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      wait_clks <= '0;
      step      <= '0;
      lo_r      <= '0;
      two       <= 1'b0;
      second    <= 1'b0;
      cmd_ready <= 1'b0;
      init_done <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_data  <= '0;
    end else begin
      cnt <= (done || start || state == IDLE) ? '0 : cnt + 32'd1;
      if (start) begin
        state     <= SETUP;
        if (state != IDLE) step <= rom_idx;
        lo_r      <= src_byte[3:0];
        two       <= src_two;
        second    <= 1'b0;
        wait_clks <= src_us * TICK_C;
        cmd_ready <= 1'b0;
        lcd_rs    <= src_rs;
        lcd_data  <= BUS_WIDTH'(BUS_WIDTH == 8 ? src_byte : src_byte >> 4);
      end else begin
        case (state)
          SETUP: if (done) begin
            state <= E_HIGH;
            lcd_e <= 1'b1;
          end
          E_HIGH: if (done) begin
            state <= HOLD;
            lcd_e <= 1'b0;
          end
          HOLD: if (done) begin
            if (two && !second) begin
              second   <= 1'b1;
              lcd_data <= BUS_WIDTH'(lo_r);
              state    <= SETUP;
            end else state <= init_done ? EXEC_WAIT : INIT;
          end
          INIT, EXEC_WAIT: if (done) begin
            state     <= IDLE;
            init_done <= 1'b1;
            cmd_ready <= 1'b1;
            lcd_rs    <= 1'b0;
            lcd_data  <= '0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb_lcd_hd44780_ctrl: checks init sequences (4/8-bit), command timing and reset behaviour against a pulse-list model
module tb_lcd_hd44780_ctrl;
  logic clk = 1'b0, nrst = 1'b0, cmd_valid = 1'b0, cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic rdy4, done4, rs4, rw4, e4;
  logic [3:0] d4;
  logic rdy8, done8, rs8, rw8, e8;
  logic [7:0] d8;
  int total = 0, bad = 0, long_e = 0;
  longint cyc = 0;
  logic pe4 = 1'b0, pe8 = 1'b0;
  typedef struct {logic rs; logic [7:0] d; longint t;} pulse_t;
  pulse_t act4[$], act8[$], exp4[$], exp8[$];

  lcd_hd44780_ctrl #(.CLK_HZ(1_000_000), .BUS_WIDTH(4), .TWO_LINE(1), .POWERUP_US(100),
    .EXEC_US(50), .CLEAR_US(2000)) u4 (
    .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_data(cmd_data),
    .cmd_ready(rdy4), .init_done(done4), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_e(e4), .lcd_data(d4));

  lcd_hd44780_ctrl #(.CLK_HZ(1_000_000), .BUS_WIDTH(8), .TWO_LINE(1), .POWERUP_US(100),
    .EXEC_US(50), .CLEAR_US(2000)) u8 (
    .clk(clk), .nrst(nrst), .cmd_valid(1'b0), .cmd_rs(1'b0), .cmd_data(8'h00),
    .cmd_ready(rdy8), .init_done(done8), .lcd_rs(rs8), .lcd_rw(rw8), .lcd_e(e8), .lcd_data(d8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic pulse_t mk(input logic rs, input logic [7:0] d, input longint t);
    pulse_t p;
    p.rs = rs;
    p.d = d;
    p.t = t;
    return p;
  endfunction

  always @(negedge clk) begin
    if (e4 && !pe4) act4.push_back(mk(rs4, {4'h0, d4}, cyc));
    if (e8 && !pe8) act8.push_back(mk(rs8, d8, cyc));
    if ((e4 && pe4) || (e8 && pe8)) long_e++;
    pe4 = e4;
    pe8 = e8;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned w_of(input logic rs, input logic [7:0] b);
    return (!rs && b < 8'h04) ? 2000 : 50;
  endfunction

  task automatic cmp_pulses(input string tag, input bit w8);
    pulse_t a[$], e[$];
    if (w8) begin a = act8; e = exp8; act8.delete(); exp8.delete(); end
    else begin a = act4; e = exp4; act4.delete(); exp4.delete(); end
    chk({tag, "_count"}, 64'(a.size()), 64'(e.size()));
    for (int i = 0; i < e.size(); i++)
      if (i < a.size()) begin
        chk($sformatf("%s[%0d].rs", tag, i), 64'(a[i].rs), 64'(e[i].rs));
        chk($sformatf("%s[%0d].data", tag, i), 64'(a[i].d), 64'(e[i].d));
        chk($sformatf("%s[%0d].time", tag, i), 64'(a[i].t), 64'(e[i].t));
      end
  endtask

  task automatic model_init(input longint rel);
    int unsigned ww[4];
    logic [7:0] b4[5], b8[5];
    longint t;
    ww = '{4100, 100, 100, 100};
    b4 = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0c};
    b8 = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0c};
    t = rel + 101;
    for (int i = 0; i < 4; i++) begin
      exp4.push_back(mk(1'b0, i == 3 ? 8'h02 : 8'h03, t));
      t += 3 + ww[i];
    end
    for (int i = 0; i < 5; i++) begin
      exp4.push_back(mk(1'b0, b4[i] >> 4, t));
      exp4.push_back(mk(1'b0, b4[i] & 8'h0f, t + 3));
      t += 6 + w_of(1'b0, b4[i]);
    end
    t = rel + 101;
    for (int i = 0; i < 3; i++) begin
      exp8.push_back(mk(1'b0, 8'h30, t));
      t += 3 + ww[i];
    end
    for (int i = 0; i < 5; i++) begin
      exp8.push_back(mk(1'b0, b8[i], t));
      t += 3 + w_of(1'b0, b8[i]);
    end
  endtask

  task automatic run_init();
    longint rel, td4, td8, last4, last8;
    int n;
    act4.delete(); act8.delete(); exp4.delete(); exp8.delete();
    @(negedge clk);
    nrst = 1'b1;
    rel = cyc;
    model_init(rel);
    last4 = exp4[exp4.size()-1].t;
    last8 = exp8[exp8.size()-1].t;
    td4 = -1;
    td8 = -1;
    n = 0;
    while ((td4 < 0 || td8 < 0) && n < 10000) begin
      @(negedge clk);
      n++;
      if (done4 && td4 < 0) td4 = cyc;
      if (done8 && td8 < 0) td8 = cyc;
    end
    chk("init_done4", 64'(done4), 64'(1));
    chk("init_done8", 64'(done8), 64'(1));
    chk("init_done4_time", 64'(td4), 64'(last4 + 2 + w_of(1'b0, 8'h0c)));
    chk("init_done8_time", 64'(td8), 64'(last8 + 2 + w_of(1'b0, 8'h0c)));
    chk("idle_ready4", 64'(rdy4), 64'(1));
    chk("idle_data4", 64'(d4), 64'(0));
    chk("idle_rs4", 64'(rs4), 64'(0));
    chk("idle_data8", 64'(d8), 64'(0));
    cmp_pulses("init4", 1'b0);
    cmp_pulses("init8", 1'b1);
    chk("e_width", 64'(long_e), 64'(0));
  endtask

  task automatic xfer(input logic rs, input logic [7:0] d, input bit keep, input logic [7:0] nd);
    longint ta, tr;
    int n;
    cmd_rs = rs;
    cmd_data = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!rdy4 && n < 5000) begin @(negedge clk); n++; end
    ta = cyc + 1;
    @(negedge clk);
    chk($sformatf("ready_drop_%02h", d), 64'(rdy4), 64'(0));
    if (keep) cmd_data = nd;
    else begin
      cmd_valid = 1'b0;
      cmd_data = ~d;
      cmd_rs = ~rs;
    end
    exp4.push_back(mk(rs, d >> 4, ta + 1));
    exp4.push_back(mk(rs, d & 8'h0f, ta + 4));
    n = 0;
    while (!rdy4 && n < 5000) begin @(negedge clk); n++; end
    tr = cyc;
    chk($sformatf("ready_gap_%02h", d), 64'(tr - ta), 64'(6 + w_of(rs, d)));
    cmp_pulses($sformatf("cmd_%02h", d), 1'b0);
  endtask

  initial begin
    int n;
    logic r;
    logic [7:0] b;
    repeat (10) @(negedge clk);
    chk("rst_e4", 64'(e4), 64'(0));
    chk("rst_rs4", 64'(rs4), 64'(0));
    chk("rst_rw4", 64'(rw4), 64'(0));
    chk("rst_data4", 64'(d4), 64'(0));
    chk("rst_ready4", 64'(rdy4), 64'(0));
    chk("rst_done4", 64'(done4), 64'(0));
    chk("rst_e8", 64'(e8), 64'(0));
    chk("rst_rs8", 64'(rs8), 64'(0));
    chk("rst_rw8", 64'(rw8), 64'(0));
    chk("rst_data8", 64'(d8), 64'(0));
    chk("rst_ready8", 64'(rdy8), 64'(0));
    chk("rst_done8", 64'(done8), 64'(0));
    run_init();
    xfer(1'b1, 8'h41, 1'b0, 8'h00);
    xfer(1'b0, 8'h01, 1'b1, 8'h55);
    xfer(1'b0, 8'h55, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      r = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      if (i == 3) begin
        r = 1'b0;
        b = 8'($urandom_range(0, 3));
      end
      xfer(r, b, 1'b0, 8'h00);
    end
    chk("rw4_tied", 64'(rw4), 64'(0));
    @(negedge clk);
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    act4.delete();
    act8.delete();
    nrst = 1'b1;
    n = 0;
    while (act4.size() < 5 && n < 10000) begin @(negedge clk); #1; n++; end
    chk("mid_e_high", 64'(e4), 64'(1));
    nrst = 1'b0;
    #1;
    chk("mid_rst_e4", 64'(e4), 64'(0));
    chk("mid_rst_done4", 64'(done4), 64'(0));
    chk("mid_rst_ready4", 64'(rdy4), 64'(0));
    chk("mid_rst_data4", 64'(d4), 64'(0));
    repeat (4) @(negedge clk);
    chk("mid_rst_e4_hold", 64'(e4), 64'(0));
    chk("mid_rst_done8", 64'(done8), 64'(0));
    run_init();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_hd44780_ctrl.md
LCD_HD44780_CTRL -- requirements
Module: lcd_hd44780_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000: clock frequency; SHALL be an integer multiple of 1_000_000.
REQ-002 SHALL have parameter BUS_WIDTH, default 4: LCD data bus width; legal values are 4 and 8 only.
REQ-003 SHALL have parameter TWO_LINE, default 1: sets function-set bit N (1 = two-line display).
REQ-004 SHALL have parameter POWERUP_US, default 20000: delay after reset before the first LCD access.
REQ-005 SHALL have parameter EXEC_US, default 50: post-command wait for normal commands and data.
REQ-006 SHALL have parameter CLEAR_US, default 2000: post-command wait for clear and home.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port cmd_valid, input, 1 bit: the requester offers a byte.
REQ-010 SHALL have port cmd_rs, input, 1 bit: 0 = instruction, 1 = data.
REQ-011 SHALL have port cmd_data, input, 8 bits: byte to write.
REQ-012 SHALL have port cmd_ready, output, 1 bit: the controller can accept a byte.
REQ-013 SHALL have port init_done, output, 1 bit: initialisation is complete; sticky until reset.
REQ-014 SHALL have port lcd_rs, output, 1 bit: LCD register select.
REQ-015 SHALL have port lcd_rw, output, 1 bit: tied to 0 (write only).
REQ-016 SHALL have port lcd_e, output, 1 bit: LCD enable strobe.
REQ-017 SHALL have port lcd_data, output, BUS_WIDTH bits: LCD data bus.

Function
REQ-018 SHALL derive a 1 us timebase of TICK = CLK_HZ/1_000_000 clocks; every N us interval lasts exactly N*TICK clocks.
REQ-019 SHALL issue each E pulse as three phases: SETUP (rs/data driven, E=0, 1 us), E_HIGH (E=1, 1 us), HOLD (E=0, rs/data held, 1 us).
REQ-020 SHALL, in 4-bit mode, send a full byte as the high nibble pulse followed immediately by the low nibble pulse; 8-bit mode uses one pulse.
REQ-021 SHALL follow each byte with an EXEC wait: CLEAR_US if rs=0 and data[7:2]==0 (clear or home), otherwise EXEC_US.
REQ-022 SHALL use FSM states PWR_WAIT, INIT (ROM-indexed step), IDLE, SETUP, E_HIGH, HOLD, EXEC_WAIT; HOLD returns to SETUP for the second nibble.
REQ-023 SHALL run the init sequence with RS=0 throughout, after the POWERUP_US wait, as follows.
- Wake pulses: value 0x3 pulsed once each (single pulse), followed by waits of 4100 us, 100 us and 100 us.
- In 8-bit mode the wake value is driven as 0x30.
- 4-bit mode only: single pulse 0x2, then a 100 us wait.
- Full bytes in order: function set 0x20|(BUS_WIDTH==8?0x10:0)|(TWO_LINE<<3), 0x08, 0x01, 0x06, 0x0C, each with REQ-021 waits.
REQ-024 SHALL assert init_done in the cycle the final EXEC wait ends, then enter IDLE.
REQ-025 SHALL drive cmd_ready=1 only in IDLE; a transfer occurs when cmd_valid&&cmd_ready at a clk edge, capturing cmd_rs/cmd_data; cmd_ready SHALL be 0 from the next cycle.
REQ-026 SHALL ignore cmd_valid while cmd_ready=0 (no queuing); cmd_data changes after capture SHALL have no effect.
REQ-027 SHALL, after acceptance, reassert cmd_ready exactly (3*P + W)*TICK clocks later (P = 1 or 2 pulses, W = wait us).
REQ-028 SHALL drive lcd_data=0 and lcd_rs=0 whenever in IDLE or PWR_WAIT.

Reset
REQ-029 SHALL, while nrst=0, asynchronously force lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0, cmd_ready=0, init_done=0, state=PWR_WAIT and all counters to 0.
REQ-030 SHALL, on a reset mid-pulse or mid-init, drop lcd_e immediately and restart the full sequence from PWR_WAIT after release.

Verification (CLK_HZ=1_000_000, POWERUP_US=100 unless noted)
REQ-031 SHALL cover: nrst low 10 cycles -> all outputs 0; after release, lcd_e=0 for 100 cycles, then the first SETUP.
REQ-032 SHALL cover: BUS_WIDTH=4, TWO_LINE=1 -> 14 E pulses with data 3,3,3,2,2,8,0,8,0,1,0,6,0,C, RS=0, E high 1 cycle each; init_done=1 after the final 50-cycle wait.
REQ-033 SHALL cover: BUS_WIDTH=8 -> 8 pulses with data 0x30,0x30,0x30,0x38,0x08,0x01,0x06,0x0C; 2000-cycle gap after 0x01.
REQ-034 SHALL cover: after init, send cmd_rs=1, cmd_data=0x41 (4-bit) -> pulses 0x4 then 0x1 with lcd_rs=1; cmd_ready high again 56 cycles after acceptance.
REQ-035 SHALL cover: send cmd_rs=0, 0x01, then hold cmd_valid with 0x55 -> cmd_ready low for 2006 cycles, no extra pulses, and 0x55 accepted afterward.
REQ-036 SHALL cover: nrst pulsed low during an E_HIGH phase of init -> lcd_e=0 in the same cycle, init_done stays 0, and the sequence restarts with a fresh 100-cycle power-up wait.
